// File: rtl/tt_um_alu_dec_rx_if.sv
// Stream interface between the tt_um pin shell and the ALU decrypt/receive core:
// ciphertext/key input side, plaintext output side and status.
interface tt_um_alu_dec_rx_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       key_load;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       ovf;
    logic [2:0] count;

    modport master (
        output in_data, in_valid, key_load, out_ready,
        input  in_ready, out_data, out_valid, ovf, count
    );

    modport slave (
        input  in_data, in_valid, key_load, out_ready,
        output in_ready, out_data, out_valid, ovf, count
    );
endinterface

// File: rtl/tt_um_alu_dec_rx.sv
// ALU ENC receive side: XOR-decrypts ciphertext bytes with a loadable key and
// buffers the recovered {a,b} operand bytes in a 4-entry FIFO.
module tt_um_alu_dec_rx_core #(
    parameter logic [7:0] KEY = 8'hAB
) (
    input logic                  clk,
    input logic                  rst_n,
    tt_um_alu_dec_rx_if.slave    bus
);
    localparam int unsigned DEPTH = 4;

    logic [7:0] key_q, key_d;
    logic [7:0] mem_q [DEPTH];
    logic [7:0] mem_d [DEPTH];
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [2:0] count_q, count_d;
    logic       ovf_q, ovf_d;

    logic full, empty;
    logic push_req, push_ok, pop_ok, key_ld;

    assign full  = (count_q == 3'(DEPTH));
    assign empty = (count_q == 3'd0);

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign bus.ovf       = ovf_q;
    assign bus.count     = count_q;

    // Classify this edge's handshakes; a full FIFO drops the push even if a pop frees a slot
    always_comb begin
        key_ld   = bus.in_valid && bus.key_load;
        push_req = bus.in_valid && !bus.key_load;
        push_ok  = push_req && !full;
        pop_ok   = bus.out_ready && !empty;
    end

    // Next-state for key, storage, pointers, occupancy and sticky overflow
    always_comb begin
        key_d    = key_q;
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (key_ld) begin
            key_d = bus.in_data;
        end

        if (push_ok) begin
            mem_d[wr_ptr_q] = bus.in_data ^ key_q;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end else if (push_req) begin
            ovf_d = 1'b1;
        end

        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end

        if (push_ok && !pop_ok) begin
            count_d = count_q + 3'd1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 3'd1;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q    <= KEY;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            key_q    <= key_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// TinyTapeout pin shell: maps the bidirectional pins onto the core stream interface.
module tt_um_alu_dec_rx (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    tt_um_alu_dec_rx_if core_bus ();

    assign core_bus.in_data   = ui_in;
    assign core_bus.in_valid  = uio_in[0];
    assign core_bus.out_ready = uio_in[1];
    assign core_bus.key_load  = uio_in[2];

    tt_um_alu_dec_rx_core #(.KEY(8'hAB)) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (core_bus.slave)
    );

    // A full FIFO shows count bits 00; in_ready=0 distinguishes it from empty
    assign uo_out  = core_bus.out_data;
    assign uio_out = {core_bus.out_valid, core_bus.in_ready, core_bus.ovf,
                      core_bus.count[1:0], 3'b000};
    assign uio_oe  = 8'b11111000;

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in[7:3], core_bus.count[2]};
endmodule

// File: tb/tb_tt_um_alu_dec_rx.sv
// Scoreboard bench for tt_um_alu_dec_rx: queue-based reference model plus a
// negedge monitor, directed scenarios followed by randomized traffic.
module tb_tt_um_alu_dec_rx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] uo_out, uio_out, uio_oe;

    tt_um_alu_dec_rx_if bus ();

    always #5 clk = ~clk;

    tt_um_alu_dec_rx dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (bus.in_data),
        .uo_out  (uo_out),
        .uio_in  ({5'b00000, bus.key_load, bus.out_ready, bus.in_valid}),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    assign bus.out_data  = uo_out;
    assign bus.out_valid = uio_out[7];
    assign bus.in_ready  = uio_out[6];
    assign bus.ovf       = uio_out[5];
    assign bus.count     = {1'b0, uio_out[4:3]};

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] sb[$];
    logic [7:0] model_key;
    logic       model_ovf;
    int         model_cnt;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%02h expected=%02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        sb.delete();
        model_key = 8'hAB;
        model_ovf = 1'b0;
        model_cnt = 0;
    endtask

    // Reference model: applies the edge's key load / push / pop to the queue
    always @(posedge clk) begin
        if (rst_n) begin
            int  occ;
            bit  popd, pushed;
            occ    = model_cnt;
            popd   = bus.out_ready && (occ > 0);
            pushed = 1'b0;
            if (bus.in_valid && bus.key_load) begin
                model_key = bus.in_data;
            end else if (bus.in_valid) begin
                if (occ < 4) begin
                    sb.push_back(bus.in_data ^ model_key);
                    pushed = 1'b1;
                end else begin
                    model_ovf = 1'b1;
                end
            end
            model_cnt = occ + int'(pushed) - int'(popd);
        end
    end

    // Monitor: compares presented outputs to the scoreboard, retiring the head on handshake
    always @(negedge clk) begin
        if (rst_n) begin
            int n;
            n = sb.size();
            chk("out_valid", {7'd0, bus.out_valid}, {7'd0, n != 0});
            chk("in_ready", {7'd0, bus.in_ready}, {7'd0, n != 4});
            chk("count", {5'd0, bus.count}, 8'(n % 4));
            chk("ovf", {7'd0, bus.ovf}, {7'd0, model_ovf});
            if (n > 0) begin
                chk("head", bus.out_data, sb[0]);
                if (bus.out_ready) void'(sb.pop_front());
            end else begin
                chk("empty_out", bus.out_data, 8'h00);
            end
        end
    end

    task automatic cyc(input logic v, input logic kl, input logic rdy, input logic [7:0] d);
        bus.in_valid  = v;
        bus.key_load  = kl;
        bus.out_ready = rdy;
        bus.in_data   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.key_load = 1'b0; bus.out_ready = 1'b0; bus.in_data = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_dut();
        chk("rst_uo_out", uo_out, 8'h00);
        chk("rst_uio_out", uio_out, 8'h40);
        chk("rst_uio_oe", uio_oe, 8'hF8);

        // 1: single push then pop
        cyc(1, 0, 0, 8'hE8);
        chk("t1_head", uo_out, 8'h43);
        chk("t1_status", uio_out, 8'hC8);
        cyc(0, 0, 1, 8'h00);
        chk("t1_after_pop", uo_out, 8'h00);
        chk("t1_valid", {7'd0, uio_out[7]}, 8'h00);

        // 2: fill, overflow, drain in order
        cyc(1, 0, 0, 8'hAB);
        cyc(1, 0, 0, 8'hAA);
        cyc(1, 0, 0, 8'hA9);
        cyc(1, 0, 0, 8'hA8);
        cyc(1, 0, 0, 8'h00);
        chk("t2_head", uo_out, 8'h00);
        chk("t2_status", uio_out, 8'hA0);
        for (int i = 0; i < 4; i++) begin
            chk("t2_order", uo_out, 8'(i));
            cyc(0, 0, 1, 8'h00);
        end
        chk("t2_drained", uio_out, 8'h60);

        // 3: key change applies only to later pushes; key_load without in_valid ignored
        cyc(1, 0, 0, 8'hE8);
        cyc(1, 1, 0, 8'h55);
        cyc(0, 1, 0, 8'hFF);
        cyc(1, 0, 0, 8'h5A);
        chk("t3_count", {6'd0, uio_out[4:3]}, 8'h02);
        chk("t3_old_key", uo_out, 8'h43);
        cyc(0, 0, 1, 8'h00);
        chk("t3_new_key", uo_out, 8'h0F);
        cyc(0, 0, 1, 8'h00);

        // 4: steady push+pop at depth 3 across pointer wrap
        reset_dut();
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 8'($urandom));
        for (int i = 0; i < 10; i++) cyc(1, 0, 1, 8'(8'h30 + i));
        chk("t4_status", uio_out, 8'hD8);

        // 5: full with push+pop on the same edge
        cyc(1, 0, 0, 8'h77);
        chk("t5_full", uio_out, 8'h80);
        cyc(1, 0, 1, 8'h99);
        chk("t5_status", uio_out, 8'hF8);

        // 6: asynchronous reset mid-stream reverts key and empties FIFO
        reset_dut();
        cyc(1, 0, 0, 8'h12);
        cyc(1, 0, 0, 8'h34);
        cyc(1, 1, 0, 8'h55);
        bus.in_valid = 1'b0; bus.key_load = 1'b0;
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("t6_async_uo", uo_out, 8'h00);
        chk("t6_async_uio", uio_out, 8'h40);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1, 0, 0, 8'hE8);
        chk("t6_key_revert", uo_out, 8'h43);
        cyc(0, 0, 1, 8'h00);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            logic v, kl, rdy;
            v   = ($urandom % 4) != 0;
            kl  = ($urandom % 12) == 0;
            rdy = ($urandom % 2) != 0;
            cyc(v, kl, rdy, 8'($urandom));
        end
        for (int i = 0; i < 8 && sb.size() != 0; i++) cyc(0, 0, 1, 8'h00);
        chk("final_drain", {7'd0, sb.size() == 0}, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
